// File: rtl/zapper_flash_seq_if.sv
// Signal bundle between the VGA timing/light-gun front end and the zapper flash sequencer.
// Inputs are qualified per pixel clock by valid (active video); outputs are level/pulse, no ready path.
interface zapper_flash_seq_if;
  logic       trigger;
  logic       light;
  logic       valid;
  logic [9:0] col;
  logic [9:0] row;
  logic [1:0] flash_mode;
  logic       hit;
  logic       miss;
  logic       busy;

  modport master (
    output trigger, light, valid, col, row,
    input  flash_mode, hit, miss, busy
  );

  modport slave (
    input  trigger, light, valid, col, row,
    output flash_mode, hit, miss, busy
  );
endinterface

// File: rtl/zapper_flash_seq.sv
// Zapper light-gun shot sequencer: on a trigger pull, flashes one black then one white frame,
// counts photodiode samples in each, and pulses hit or miss.
module zapper_flash_seq #(
  parameter int HIT_THRESH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  zapper_flash_seq_if.slave     bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_BLACK  = 3'd2,
    S_WHITE  = 3'd3,
    S_RESULT = 3'd4,
    S_HELD   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_trig_prev;
  logic             r_armable;
  logic [CNT_W-1:0] r_black_cnt;
  logic [CNT_W-1:0] r_white_cnt;
  logic [1:0]       r_flash;
  logic             r_hit;
  logic             r_miss;

  logic             w_frame_start;
  logic             w_trig_rise;
  logic             w_sample;
  logic             w_is_hit;
  logic [CNT_W-1:0] w_cnt_max;
  logic [CNT_W-1:0] w_thresh;

  assign w_cnt_max     = '1;
  assign w_thresh      = CNT_W'(HIT_THRESH);
  assign w_frame_start = (bus.col == 10'd0) && (bus.row == 10'd0);
  // r_armable blocks a trigger that was already held through reset from firing.
  assign w_trig_rise   = bus.trigger && !r_trig_prev && r_armable;
  assign w_sample      = bus.valid && bus.light;
  assign w_is_hit      = (r_white_cnt >= w_thresh) && (r_black_cnt < w_thresh);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_trig_rise)   w_next = S_ARMED;
      S_ARMED:  if (w_frame_start) w_next = S_BLACK;
      S_BLACK:  if (w_frame_start) w_next = S_WHITE;
      S_WHITE:  if (w_frame_start) w_next = S_RESULT;
      S_RESULT:                    w_next = S_HELD;
      S_HELD:   if (!bus.trigger)  w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_trig_prev <= 1'b0;
      r_armable   <= 1'b0;
      r_black_cnt <= '0;
      r_white_cnt <= '0;
      r_flash     <= 2'b00;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_trig_prev <= bus.trigger;
      if (!bus.trigger) r_armable <= 1'b1;

      case (r_state)
        S_BLACK: r_flash <= 2'b01;
        S_WHITE: r_flash <= 2'b10;
        default: r_flash <= 2'b00;
      endcase

      r_hit  <= (r_state == S_RESULT) && w_is_hit;
      r_miss <= (r_state == S_RESULT) && !w_is_hit;

      // Counters saturate so a bright ambient scene can never wrap into a false hit.
      if (r_state == S_IDLE && w_trig_rise) begin
        r_black_cnt <= '0;
        r_white_cnt <= '0;
      end else begin
        if (r_state == S_BLACK && w_sample && r_black_cnt != w_cnt_max)
          r_black_cnt <= r_black_cnt + 1'b1;
        if (r_state == S_WHITE && w_sample && r_white_cnt != w_cnt_max)
          r_white_cnt <= r_white_cnt + 1'b1;
      end
    end
  end

  assign bus.flash_mode = r_flash;
  assign bus.hit        = r_hit;
  assign bus.miss       = r_miss;
  assign bus.busy       = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_zapper_flash_seq.sv
// Bench for zapper_flash_seq on a reduced 20x10 (200-cycle) frame with a 16x8 active area.
module tb_zapper_flash_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  zapper_flash_seq_if bus ();

  zapper_flash_seq #(.HIT_THRESH(16), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  typedef struct {
    int p;
    int nb;
    int nw;
    bit amb;
    bit retrig;
    bit exp_hit;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pos = 0;
  int fs1 = 0;
  int nb = 0, nw = 0, lit_b = 0, lit_w = 0;
  bit amb = 0;
  bit shot_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    int d;
    bus.col   = 10'(pos % 20);
    bus.row   = 10'(pos / 20);
    bus.valid = ((pos % 20) < 16) && ((pos / 20) < 8);
    bus.light = 1'b0;
    if (shot_on) begin
      d = cyc - fs1;
      if (amb) bus.light = bus.valid && d > 0 && d <= 400;
      else if (bus.valid && d >= 20 && d < 200 && lit_b < nb) begin
        bus.light = 1'b1;
        lit_b++;
      end else if (bus.valid && d >= 220 && d < 400 && lit_w < nw) begin
        bus.light = 1'b1;
        lit_w++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pos = (pos + 1) % 200;
    drive_inputs();
  endtask

  // Scoreboard: every hit/miss pulse must match the oldest expected result and its cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.hit === 1'b1 || bus.miss === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual hit=%0b miss=%0b expected none (cycle %0d)",
                 bus.hit, bus.miss, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result_kind_hit", {31'd0, bus.hit}, {31'd0, e[31]});
        chk("result_kind_miss", {31'd0, bus.miss}, {31'd0, ~e[31]});
        chk("result_cycle", 32'(cyc), {1'b0, e[30:0]});
      end
    end
  end

  task automatic shot(input vec_t v);
    int c_t, due, n01, n10;
    tick();
    while (pos != v.p) tick();
    bus.trigger = 1'b1;
    c_t   = cyc;
    fs1   = c_t + 200 - v.p;
    nb    = v.nb;
    nw    = v.nw;
    amb   = v.amb;
    lit_b = 0;
    lit_w = 0;
    shot_on = 1'b1;
    due = fs1 + 402;
    exp_q.push_back({v.exp_hit, 31'(due)});
    n01 = 0;
    n10 = 0;
    while (cyc < due + 5) begin
      tick();
      if (v.retrig) begin
        if (cyc == fs1 + 50)  bus.trigger = 1'b0;
        if (cyc == fs1 + 300) bus.trigger = 1'b1;
      end
      if (bus.flash_mode == 2'b01) n01++;
      if (bus.flash_mode == 2'b10) n10++;
      if (cyc == fs1 - 1)   chk("flash_armed", 32'(bus.flash_mode), 32'd0);
      if (cyc == fs1 + 100) chk("flash_black", 32'(bus.flash_mode), 32'd1);
      if (cyc == fs1 + 300) chk("flash_white", 32'(bus.flash_mode), 32'd2);
      if (cyc == fs1 + 350) chk("busy_white", 32'(bus.busy), 32'd1);
    end
    chk("black_frame_len", 32'(n01), 32'd200);
    chk("white_frame_len", 32'(n10), 32'd200);
    chk("result_seen", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
    chk("flash_after", 32'(bus.flash_mode), 32'd0);
    chk("busy_held", 32'(bus.busy), 32'd1);
    bus.trigger = 1'b0;
    tick();
    chk("busy_release", 32'(bus.busy), 32'd0);
    shot_on = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{p: 100, nb: 0,  nw: 20, amb: 0, retrig: 0, exp_hit: 1};
    vecs[1] = '{p: 100, nb: 0,  nw: 0,  amb: 1, retrig: 0, exp_hit: 0};
    vecs[2] = '{p: 100, nb: 0,  nw: 15, amb: 0, retrig: 0, exp_hit: 0};
    vecs[3] = '{p: 100, nb: 0,  nw: 16, amb: 0, retrig: 0, exp_hit: 1};
    vecs[4] = '{p: 100, nb: 16, nw: 20, amb: 0, retrig: 0, exp_hit: 0};
    vecs[5] = '{p: 100, nb: 15, nw: 20, amb: 0, retrig: 0, exp_hit: 1};
    vecs[6] = '{p: 100, nb: 0,  nw: 20, amb: 0, retrig: 1, exp_hit: 1};
    vecs[7] = '{p: 0,   nb: 0,  nw: 20, amb: 0, retrig: 0, exp_hit: 1};

    reset       = 1'b1;
    bus.trigger = 1'b1;
    drive_inputs();
    for (int i = 0; i < 3; i++) tick();
    chk("rst_flash", 32'(bus.flash_mode), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_miss", 32'(bus.miss), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.busy !== 1'b0) bad++;
    end
    chk("held_trigger_after_reset", 32'(bad), 32'd0);
    bus.trigger = 1'b0;
    tick();

    foreach (vecs[i]) shot(vecs[i]);

    tick();
    while (pos != 100) tick();
    bus.trigger = 1'b1;
    fs1   = cyc + 100;
    nb    = 0;
    nw    = 20;
    amb   = 0;
    lit_b = 0;
    lit_w = 0;
    shot_on = 1'b1;
    while (cyc < fs1 + 300) tick();
    chk("pre_reset_flash", 32'(bus.flash_mode), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_flash", 32'(bus.flash_mode), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    bad = 0;
    while (cyc < fs1 + 1000) begin
      tick();
      if (bus.busy !== 1'b0 || bus.flash_mode !== 2'b00) bad++;
    end
    chk("abort_stays_idle", 32'(bad), 32'd0);
    shot_on = 1'b0;
    bus.trigger = 1'b0;
    tick();

    shot(vecs[0]);

    for (int i = 0; i < 5; i++) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
